// File: rtl/arcsin_lut_loader_if.sv
// Table-word stream from the control/DMA side into the arcsin LUT loader.
// master: the word source. slave: the loader.
interface arcsin_lut_loader_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/arcsin_lut_loader.sv
// arcsin_lut_loader: writes a new arcsin table into the shadow half of a
// double-banked LUT RAM, then flips the reader onto it at a reader-signalled
// safe instant (swap_ok).
// Optional feature: define ARCSIN_LUT_LOADER_CHECKSUM_EN to accumulate a
// 32-bit checksum of the loaded words and refuse the swap when it does not
// match exp_sum.
module arcsin_lut_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_abort,
  arcsin_lut_loader_if.slave    din_if,
  input  logic                  swap_ok,
  input  logic [31:0]           exp_sum,
  output logic                  lut_we,
  output logic [ADDR_WIDTH:0]   lut_waddr,
  output logic [DATA_WIDTH-1:0] lut_wdata,
  output logic                  active_bank,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           sum
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_SWAP = 2'd2,
    FAIL      = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    lut_we_q, lut_we_d;
  logic [ADDR_WIDTH:0]     lut_waddr_q, lut_waddr_d;
  logic [DATA_WIDTH-1:0]   lut_wdata_q, lut_wdata_d;
  logic                    active_bank_q, active_bank_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [31:0]             sum_q, sum_d;

`ifdef ARCSIN_LUT_LOADER_CHECKSUM_EN
  logic [31:0] sum_next;
  assign sum_next = sum_q + 32'(din_if.din);
`else
  logic unused_exp_sum;
  assign unused_exp_sum = ^exp_sum;
`endif

  // Next-state and registered-output logic; abort outranks every other event.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lut_we_d      = 1'b0;
    lut_waddr_d   = lut_waddr_q;
    lut_wdata_d   = lut_wdata_q;
    active_bank_d = active_bank_q;
    done_d        = 1'b0;
    err_d         = err_q;
    sum_d         = sum_q;

    case (state_q)
      IDLE: begin
        if (load_start && !load_abort) begin
          state_d = LOAD;
          cnt_d   = '0;
          sum_d   = '0;
          err_d   = 1'b0;
        end
      end

      LOAD: begin
        if (load_abort) begin
          state_d = IDLE;
        end else if (din_if.din_valid) begin
          lut_we_d    = 1'b1;
          lut_waddr_d = {~active_bank_q, cnt_q};
          lut_wdata_d = din_if.din;
          cnt_d       = cnt_q + 1'b1;
`ifdef ARCSIN_LUT_LOADER_CHECKSUM_EN
          sum_d = sum_next;
          if (cnt_q == CNT_LAST) begin
            if (sum_next == exp_sum) begin
              state_d = WAIT_SWAP;
            end else begin
              state_d = FAIL;
              err_d   = 1'b1;
            end
          end
`else
          if (cnt_q == CNT_LAST) begin
            state_d = WAIT_SWAP;
          end
`endif
        end
      end

      WAIT_SWAP: begin
        if (load_abort) begin
          state_d = IDLE;
        end else if (swap_ok) begin
          active_bank_d = ~active_bank_q;
          done_d        = 1'b1;
          state_d       = IDLE;
        end
      end

      FAIL: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      lut_we_q      <= 1'b0;
      lut_waddr_q   <= '0;
      lut_wdata_q   <= '0;
      active_bank_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      sum_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lut_we_q      <= lut_we_d;
      lut_waddr_q   <= lut_waddr_d;
      lut_wdata_q   <= lut_wdata_d;
      active_bank_q <= active_bank_d;
      done_q        <= done_d;
      err_q         <= err_d;
      sum_q         <= sum_d;
    end
  end

  assign din_if.din_ready = (state_q == LOAD);
  assign busy             = (state_q == LOAD) || (state_q == WAIT_SWAP);
  assign lut_we           = lut_we_q;
  assign lut_waddr        = lut_waddr_q;
  assign lut_wdata        = lut_wdata_q;
  assign active_bank      = active_bank_q;
  assign done             = done_q;
  assign err              = err_q;
  assign sum              = sum_q;

endmodule

// File: tb/tb_arcsin_lut_loader.sv
// Bench for arcsin_lut_loader with a 16-word table. A step-level reference
// model predicts writes and swaps into queues; a negedge monitor pops and
// compares them whenever the DUT writes or pulses done.
module tb_arcsin_lut_loader;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int WORDS = 1 << AW;
`ifdef ARCSIN_LUT_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_WAIT = 2;
  localparam int P_FAIL = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_start = 1'b0;
  logic          load_abort = 1'b0;
  logic          swap_ok = 1'b0;
  logic [31:0]   exp_sum = '0;
  logic          lut_we;
  logic [AW:0]   lut_waddr;
  logic [DW-1:0] lut_wdata;
  logic          active_bank;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   sum;

  arcsin_lut_loader_if #(.DATA_WIDTH(DW)) din_if ();

  arcsin_lut_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .load_abort  (load_abort),
    .din_if      (din_if),
    .swap_ok     (swap_ok),
    .exp_sum     (exp_sum),
    .lut_we      (lut_we),
    .lut_waddr   (lut_waddr),
    .lut_wdata   (lut_wdata),
    .active_bank (active_bank),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .sum         (sum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          phase = P_IDLE;
  int          mcnt = 0;
  bit          mbank = 1'b0;
  bit          merr = 1'b0;
  logic [31:0] msum = '0;
  logic [AW+DW:0] write_q[$];
  bit             done_q[$];
  logic [DW-1:0]  words[WORDS];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // One clock of stimulus followed by the model update and state checks.
  task automatic applyStimulus(input bit st, input bit ab, input bit v,
                               input logic [DW-1:0] d, input bit sw);
    int prev;
    prev = phase;
    load_start = st;
    load_abort = ab;
    din_if.din_valid = v;
    din_if.din = d;
    swap_ok = sw;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    load_abort = 1'b0;
    din_if.din_valid = 1'b0;
    swap_ok = 1'b0;
    case (prev)
      P_IDLE: if (st && !ab) begin phase = P_LOAD; mcnt = 0; msum = '0; merr = 1'b0; end
      P_LOAD: begin
        if (ab) phase = P_IDLE;
        else if (v) begin
          write_q.push_back({~mbank, mcnt[AW-1:0], d});
          msum = msum + 32'(d);
          mcnt++;
          if (mcnt == WORDS) begin
            if (CHK && msum != exp_sum) begin merr = 1'b1; phase = P_FAIL; end
            else phase = P_WAIT;
          end
        end
      end
      P_WAIT: begin
        if (ab) phase = P_IDLE;
        else if (sw) begin mbank = ~mbank; done_q.push_back(mbank); phase = P_IDLE; end
      end
      default: phase = P_IDLE;
    endcase
    checkOutput("busy", 32'(busy), 32'(phase == P_LOAD || phase == P_WAIT));
    checkOutput("din_ready", 32'(din_if.din_ready), 32'(phase == P_LOAD));
    checkOutput("active_bank", 32'(active_bank), 32'(mbank));
    checkOutput("err", 32'(err), 32'(CHK ? merr : 1'b0));
    checkOutput("sum", sum, CHK ? msum : 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // kind 0: base+i, 1: random, 2: constant base. delta skews exp_sum.
  task automatic prepWords(input int kind, input logic [DW-1:0] base, input logic [31:0] delta);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < WORDS; i++) begin
      case (kind)
        0: words[i] = base + DW'(i);
        1: words[i] = DW'($urandom);
        default: words[i] = base;
      endcase
      s = s + 32'(words[i]);
    end
    exp_sum = s + delta;
  endtask

  // Start a load and send the first n prepared words, optionally with gaps.
  task automatic sendWords(input int n, input bit gapped);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (gapped) applyStimulus(i == 3, 1'b0, 1'b0, DW'($urandom), 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, words[i], 1'b0);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    phase = P_IDLE; mbank = 1'b0; merr = 1'b0; msum = '0;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_din_ready", 32'(din_if.din_ready), 0);
    checkOutput("rst_lut_we", 32'(lut_we), 0);
    checkOutput("rst_lut_waddr", 32'(lut_waddr), 0);
    checkOutput("rst_lut_wdata", 32'(lut_wdata), 0);
    checkOutput("rst_active_bank", 32'(active_bank), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_sum", sum, 0);
  endtask

  // Scoreboard monitor: compares every DUT write and done pulse against the model.
  initial begin
    logic [AW+DW:0] e;
    bit eb;
    forever begin
      @(negedge clk);
      if (lut_we === 1'b1) begin
        if (write_q.size() == 0) checkOutput("unexpected_write", {11'd0, lut_waddr, lut_wdata}, 0);
        else begin
          e = write_q.pop_front();
          checkOutput("write_addr", 32'(lut_waddr), 32'(e[AW+DW:DW]));
          checkOutput("write_data", 32'(lut_wdata), 32'(e[DW-1:0]));
        end
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) checkOutput("unexpected_done", 1, 0);
        else begin
          eb = done_q.pop_front();
          checkOutput("done_bank", 32'(active_bank), 32'(eb));
        end
      end
    end
  end

  initial begin
    din_if.din = '0;
    din_if.din_valid = 1'b0;
    idle_pre: begin
      @(posedge clk);
    end
    doReset();

    // Full load of 0x0100..0x010F, swap 5 cycles later
    prepWords(0, 16'h0100, 0);
    sendWords(WORDS, 1'b0);
    idle(4);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(1);

    // Gapped random load into bank 0, with an ignored load_start mid-load
    prepWords(1, '0, 0);
    sendWords(WORDS, 1'b1);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(1);

    // Abort after 7 words, then a fresh load restarting at 0x10
    prepWords(1, '0, 0);
    sendWords(7, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    idle(2);
    prepWords(1, '0, 0);
    sendWords(WORDS, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(1);

    // Abort coincident with swap_ok: no toggle, no done
    prepWords(1, '0, 0);
    sendWords(WORDS, 1'b0);
    idle(1);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
    idle(2);

    // load_start with load_abort in IDLE stays idle
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
    idle(1);

    // Checksum match: all 0x0001, exp_sum 16
    prepWords(2, 16'h0001, 0);
    sendWords(WORDS, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(1);

    // Checksum mismatch: exp_sum 15; swap only happens without the checksum feature
    prepWords(2, 16'h0001, 32'hFFFF_FFFF);
    sendWords(WORDS, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(2);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
    idle(1);

    // Reset mid-load
    prepWords(1, '0, 0);
    sendWords(5, 1'b0);
    doReset();
    idle(2);

    checkOutput("write_queue_empty", write_q.size(), 0);
    checkOutput("done_queue_empty", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
